// File: rtl/oled_frame_streamer.sv
// -----------------------------------------------------------------------------
// oled_frame_streamer
//
// Streams full frames of RGB565 pixels to a 96x64 SPI OLED panel. For every
// pixel the block presents pixel_index to the sprite/pixel generators, waits
// for their registered colour, latches it, and shifts the 16 bits out MSB
// first in SPI mode 0. After the last pixel of a frame, cs_n is raised for a
// fixed gap. If enable is still high at the end of the gap, the next frame
// begins; otherwise the block returns to IDLE.
//
// Ports
//   clk         : system clock (only clock)
//   reset       : synchronous, active-high reset
//   enable      : level request to stream frames continuously
//   pixel_index : pixel address presented to the generators (row*96 + col)
//   oled_data   : RGB565 colour for pixel_index, valid 1 clk after it changes
//   sclk        : SPI serial clock, idle low
//   mosi        : SPI serial data, MSB first
//   cs_n        : chip select, active low, held low for the whole frame
//   dc          : data/command select, tied to 1 (pixel data)
//   busy        : high while a frame (including its trailing gap) runs
//   frame_done  : one-clk pulse when the last bit of a frame has been sent
// -----------------------------------------------------------------------------
module oled_frame_streamer #(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_GAP  = 16,
  parameter int NUM_PIXELS = 6144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [12:0] pixel_index,
  input  logic [15:0] oled_data,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        dc,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [9:0]  GAP_LAST = 10'(FRAME_GAP - 1);
  localparam logic [12:0] PIX_LAST = 13'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e      state_q,  state_d;
  logic [12:0] pix_q,    pix_d;
  logic [7:0]  div_q,    div_d;     // clk count within one sclk half-period
  logic [3:0]  bit_q,    bit_d;     // bits already completed in this pixel
  logic        phase_q,  phase_d;   // 0: sclk low half, 1: sclk high half
  logic        fetch_q,  fetch_d;   // second FETCH cycle marker
  logic [9:0]  gap_q,    gap_d;
  logic [15:0] shreg_q,  shreg_d;
  logic        sclk_q,   sclk_d;
  logic        mosi_q,   mosi_d;
  logic        cs_n_q,   cs_n_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;

  // Control and output registers are reset; the shift register holds pure
  // data and is always reloaded in FETCH before it is used.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      fetch_q <= 1'b0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      fetch_q <= fetch_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    fetch_d = fetch_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FETCH;
          pix_d   = '0;
          fetch_d = 1'b0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      // Two cycles: the generators see pixel_index in the first and return
      // their registered colour in time for the second.
      FETCH: begin
        if (fetch_q) begin
          state_d = SHIFT;
          shreg_d = oled_data;
          mosi_d  = oled_data[15];
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          fetch_d = 1'b1;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            // End of a high half: sclk falls, and only now may mosi move.
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q == 4'd15) begin
              mosi_d  = 1'b0;
              fetch_d = 1'b0;
              if (pix_q == PIX_LAST) begin
                state_d = GAP;
                pix_d   = '0;
                cs_n_d  = 1'b1;
                done_d  = 1'b1;
                gap_d   = '0;
              end else begin
                state_d = FETCH;
                pix_d   = pix_q + 13'd1;
              end
            end else begin
              bit_d   = bit_q + 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
              mosi_d  = shreg_q[14];
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (enable) begin
            state_d = FETCH;
            fetch_d = 1'b0;
            cs_n_d  = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q + 10'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign pixel_index = pix_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;
  assign dc          = 1'b1;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Testbench for oled_frame_streamer. Three instances:
//   a: default parameters, per-cycle vector table, reset and random-data cases
//   b: CLK_DIV=1, NUM_PIXELS=8, pixel model oled_data = registered pixel_index
//   c: CLK_DIV=3, NUM_PIXELS=4, FRAME_GAP=4, sclk phase and pixel-period timing
module tb_oled_frame_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // ---------------- instance a ----------------
  logic        a_rst, a_en;
  logic [15:0] a_dat;
  logic [12:0] a_pix;
  logic        a_sclk, a_mosi, a_cs_n, a_dc, a_busy, a_fd;

  oled_frame_streamer u_a (
    .clk(clk), .reset(a_rst), .enable(a_en), .pixel_index(a_pix),
    .oled_data(a_dat), .sclk(a_sclk), .mosi(a_mosi), .cs_n(a_cs_n),
    .dc(a_dc), .busy(a_busy), .frame_done(a_fd)
  );

  // ---------------- instance b ----------------
  logic        b_rst, b_en;
  logic [15:0] b_dat;
  logic [12:0] b_pix;
  logic        b_sclk, b_mosi, b_cs_n, b_dc, b_busy, b_fd;

  oled_frame_streamer #(.CLK_DIV(1), .FRAME_GAP(16), .NUM_PIXELS(8)) u_b (
    .clk(clk), .reset(b_rst), .enable(b_en), .pixel_index(b_pix),
    .oled_data(b_dat), .sclk(b_sclk), .mosi(b_mosi), .cs_n(b_cs_n),
    .dc(b_dc), .busy(b_busy), .frame_done(b_fd)
  );

  always @(posedge clk) b_dat <= {3'b000, b_pix};

  // ---------------- instance c ----------------
  logic        c_rst, c_en;
  logic [15:0] c_dat;
  logic [12:0] c_pix;
  logic        c_sclk, c_mosi, c_cs_n, c_dc, c_busy, c_fd;

  oled_frame_streamer #(.CLK_DIV(3), .FRAME_GAP(4), .NUM_PIXELS(4)) u_c (
    .clk(clk), .reset(c_rst), .enable(c_en), .pixel_index(c_pix),
    .oled_data(c_dat), .sclk(c_sclk), .mosi(c_mosi), .cs_n(c_cs_n),
    .dc(c_dc), .busy(c_busy), .frame_done(c_fd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Main sequence samples 2 time units after the edge; monitors sample at 1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- SPI decoders / scoreboards ----------------
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] a_word, b_word;
  int a_nb = 0, b_nb = 0, a_rises = 0, b_rises = 0, a_viol = 0, b_viol = 0;
  logic a_prev = 1'b0, b_prev = 1'b0, a_pm = 1'b0, b_pm = 1'b0;
  int b_maxpix = 0;

  always @(posedge clk) begin
    #1;
    if (a_cs_n) a_nb = 0;
    else if (a_sclk && !a_prev) begin
      a_rises++;
      a_word = {a_word[14:0], a_mosi};
      a_nb++;
      if (a_nb == 16) begin
        a_nb = 0;
        if (qa.size() == 0) chk("a_word_unexpected", {16'h0, a_word}, 32'hFFFF_FFFF);
        else chk("a_word", {16'h0, a_word}, {16'h0, qa.pop_front()});
      end
    end
    if (a_sclk && a_prev && (a_mosi != a_pm)) a_viol++;
    a_prev = a_sclk;
    a_pm   = a_mosi;
  end

  always @(posedge clk) begin
    #1;
    if (b_cs_n) b_nb = 0;
    else if (b_sclk && !b_prev) begin
      b_rises++;
      b_word = {b_word[14:0], b_mosi};
      b_nb++;
      if (b_nb == 16) begin
        b_nb = 0;
        if (qb.size() == 0) chk("b_word_unexpected", {16'h0, b_word}, 32'hFFFF_FFFF);
        else chk("b_word", {16'h0, b_word}, {16'h0, qb.pop_front()});
      end
    end
    if (b_sclk && b_prev && (b_mosi != b_pm)) b_viol++;
    if (int'(b_pix) > b_maxpix) b_maxpix = int'(b_pix);
    b_prev = b_sclk;
    b_pm   = b_mosi;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] dat;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        busy;
    logic [12:0] pix;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int csh, nfd, t, r0;
    a_rst = 1; a_en = 0; a_dat = 16'h0;
    b_rst = 1; b_en = 0;
    c_rst = 1; c_en = 0; c_dat = 16'h8001;

    // Per-cycle table for instance a with oled_data = A5C3 (1010_0101_...).
    tbl[0] = '{1'b1, 1'b0, 16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0}; // reset
    tbl[1] = '{1'b0, 1'b0, 16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0}; // idle
    tbl[2] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b1, 13'd0}; // FETCH 1
    tbl[3] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b1, 13'd0}; // FETCH 2
    tbl[4] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b1, 13'd0}; // bit15 low
    tbl[5] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b1, 13'd0};
    tbl[6] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b1, 1'b1, 1'b1, 13'd0}; // bit15 high
    tbl[7] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b1, 1'b1, 1'b1, 13'd0};
    tbl[8] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b1, 13'd0}; // bit14 low

    tick();
    tick();
    b_rst = 0;
    c_rst = 0;
    a_rises = 0;

    // ---- Table vectors: reset state, start-up and first bits ----
    for (int i = 0; i < 9; i++) begin
      a_rst = tbl[i].rst;
      a_en  = tbl[i].en;
      a_dat = tbl[i].dat;
      if (i == 2) qa.push_back(16'hA5C3);
      tick();
      chk($sformatf("tbl%0d_cs_n", i), {31'h0, a_cs_n}, {31'h0, tbl[i].cs_n});
      chk($sformatf("tbl%0d_sclk", i), {31'h0, a_sclk}, {31'h0, tbl[i].sclk});
      chk($sformatf("tbl%0d_mosi", i), {31'h0, a_mosi}, {31'h0, tbl[i].mosi});
      chk($sformatf("tbl%0d_busy", i), {31'h0, a_busy}, {31'h0, tbl[i].busy});
      chk($sformatf("tbl%0d_pix", i), {19'h0, a_pix}, {19'h0, tbl[i].pix});
      chk($sformatf("tbl%0d_fd_dc", i), {30'h0, a_fd, a_dc}, 32'h1);
    end

    // Remaining cycles of pixel 0: 16 rises, pixel_index -> 1 at clk 67.
    csh = 0;
    for (int k = 7; k <= 66; k++) begin
      tick();
      if (a_cs_n) csh++;
      if (k == 65) begin
        chk("a_pix_before_67", {19'h0, a_pix}, 32'd0);
        chk("a_rises_16", a_rises, 32'd16);
      end
      if (k == 66) chk("a_pix_at_67", {19'h0, a_pix}, 32'd1);
    end
    chk("a_cs_n_glitch", csh, 32'd0);
    chk("a_queue_drained", qa.size(), 32'd0);

    // ---- Reset in the middle of bit 7, enable held high ----
    a_rst = 1; tick(); a_rst = 0;
    a_en = 1; a_dat = 16'h3C5A; a_rises = 0;
    for (int k = 0; k <= 36; k++) begin
      if (k == 36) a_rst = 1;
      tick();
      if (k == 35) chk("a_rises_before_bit7_reset", a_rises, 32'd8);
    end
    chk("rst_mid_cs_n", {31'h0, a_cs_n}, 32'd1);
    chk("rst_mid_sclk", {31'h0, a_sclk}, 32'd0);
    chk("rst_mid_mosi", {31'h0, a_mosi}, 32'd0);
    chk("rst_mid_pix", {19'h0, a_pix}, 32'd0);
    chk("rst_mid_busy", {31'h0, a_busy}, 32'd0);
    a_rst = 0;
    qa.push_back(16'h3C5A);
    for (int k = 0; k <= 66; k++) begin
      tick();
      if (k == 0) chk("restart_cs_n", {31'h0, a_cs_n}, 32'd0);
      if (k == 65) chk("restart_pix0", {19'h0, a_pix}, 32'd0);
      if (k == 66) chk("restart_pix1", {19'h0, a_pix}, 32'd1);
    end
    chk("restart_queue_drained", qa.size(), 32'd0);

    // ---- Random oled_data every clk: only the end-of-FETCH value is sent ----
    a_rst = 1; tick(); a_rst = 0;
    a_viol = 0;
    a_en = 1;
    for (int k = 0; k <= 198; k++) begin
      a_dat = 16'($urandom);
      if (k >= 2 && ((k - 2) % 66) == 0) qa.push_back(a_dat);
      tick();
    end
    chk("rand_queue_drained", qa.size(), 32'd0);
    chk("rand_mosi_while_sclk_high", a_viol, 32'd0);
    a_rst = 1; a_en = 0; tick(); a_rst = 0;

    // ---- Pixel model, two frames of 8 pixels ----
    for (int r = 0; r < 2; r++) for (int p = 0; p < 8; p++) qb.push_back(16'(p));
    b_en = 1;
    nfd = 0; csh = 0; t = 0;
    while (nfd < 2 && t < 1000) begin
      tick();
      t++;
      if (b_fd) nfd++;
      if (nfd == 1 && b_cs_n) csh++;
      if (nfd == 2) b_en = 0;
    end
    chk("b_two_frames_done", nfd, 32'd2);
    chk("b_gap_cs_n_high", csh, 32'd16);
    for (int k = 0; k < 30; k++) tick();
    chk("b_words_drained", qb.size(), 32'd0);
    chk("b_idle_busy", {31'h0, b_busy}, 32'd0);
    chk("b_idle_pix", {19'h0, b_pix}, 32'd0);

    // ---- Drop enable at pixel 3: frame completes, then IDLE ----
    b_rst = 1; tick(); b_rst = 0;
    for (int p = 0; p < 8; p++) qb.push_back(16'(p));
    b_en = 1;
    t = 0;
    while (b_pix != 13'd3 && t < 500) begin tick(); t++; end
    chk("b_reached_pix3", {19'h0, b_pix}, 32'd3);
    b_en = 0;
    t = 0; nfd = 0;
    while (nfd == 0 && t < 500) begin
      tick(); t++;
      if (b_fd) nfd++;
    end
    chk("b_frame_done_after_drop", nfd, 32'd1);
    chk("b_busy_in_gap", {31'h0, b_busy}, 32'd1);
    for (int k = 0; k < 20; k++) tick();
    chk("b_drop_busy", {31'h0, b_busy}, 32'd0);
    chk("b_drop_cs_n", {31'h0, b_cs_n}, 32'd1);
    chk("b_drop_words_drained", qb.size(), 32'd0);
    r0 = b_rises;
    for (int k = 0; k < 50; k++) tick();
    chk("b_no_sclk_after_idle", b_rises - r0, 32'd0);
    chk("b_pix_limit", {31'h0, (b_maxpix > 7)}, 32'd0);
    chk("b_mosi_while_sclk_high", b_viol, 32'd0);

    // ---- CLK_DIV=3: 3-clk phases, 98-clk pixel ----
    c_en = 1;
    t = 0;
    while (!c_sclk && t < 50) begin tick(); t++; end
    chk("c_first_rise_at", t, 32'd6);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("c_sclk_phase%0d", i), {31'h0, c_sclk}, {31'h0, ((i / 3) % 2 == 0)});
      tick();
    end
    t = 0;
    while (c_pix != 13'd1 && t < 200) begin tick(); t++; end
    chk("c_reached_pix1", {19'h0, c_pix}, 32'd1);
    t = 0;
    while (c_pix == 13'd1 && t < 200) begin tick(); t++; end
    chk("c_pixel_period", t, 32'd98);
    c_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/oled_frame_streamer.md
OLED_FRAME_STREAMER -- requirements
Module: oled_frame_streamer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, giving the number of clk cycles per sclk half-period (legal range 1..255).
REQ-002 SHALL have parameter FRAME_GAP, default 16, giving the number of clk cycles cs_n is held high between frames (legal range 1..1023).
REQ-003 SHALL have parameter NUM_PIXELS, default 6144, giving the pixel count of one 96x64 frame.
REQ-004 Port: clk  input  1  system clock; the only clock.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: enable  input  1  level request to stream frames continuously.
REQ-007 Port: pixel_index  output  13  address presented to sprite/pixel generators (row*96 + col).
REQ-008 Port: oled_data  input  16  RGB565 colour returned by the generators, registered 1 clk after pixel_index.
REQ-009 Port: sclk  output  1  serial clock to the display, idle low.
REQ-010 Port: mosi  output  1  serial data to the display, MSB first.
REQ-011 Port: cs_n  output  1  chip select, active low.
REQ-012 Port: dc  output  1  data/command select; always 1 (pixel data).
REQ-013 Port: busy  output  1  high while a frame is in progress, including the gap.
REQ-014 Port: frame_done  output  1  one-clk pulse at the end of each frame.

Function
REQ-015 SHALL implement states IDLE, FETCH, SHIFT and GAP.
REQ-016 IDLE: cs_n=1, sclk=0, mosi=0, busy=0, pixel_index=0; enable=1 -> FETCH on the next clk, with cs_n=0 and busy=1.
REQ-017 FETCH SHALL last exactly 2 clk cycles with pixel_index stable, then latch oled_data into a 16-bit shift register and enter SHIFT.
REQ-018 SHIFT SHALL send 16 bits, MSB (bit 15) first, SPI mode 0.
REQ-019 For each bit in SHIFT: mosi is driven with the bit value while sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
REQ-020 mosi SHALL change only while sclk=0.
REQ-021 Per-pixel time SHALL be exactly 2 + 32*CLK_DIV clk cycles (66 at default).
REQ-022 After bit 0's high phase, when pixel_index < NUM_PIXELS-1: sclk=0, pixel_index increments by 1, return to FETCH.
REQ-023 After bit 0's high phase, when pixel_index = NUM_PIXELS-1: enter GAP; cs_n=1, sclk=0, mosi=0, pixel_index wraps to 0, frame_done=1 for that one clk.
REQ-024 GAP SHALL last FRAME_GAP cycles; at its end, enable=1 -> FETCH (cs_n=0), enable=0 -> IDLE.
REQ-025 enable deasserted mid-frame SHALL NOT abort; the current frame completes and the block then goes to IDLE after GAP.
REQ-026 pixel_index SHALL never exceed NUM_PIXELS-1.
REQ-027 cs_n SHALL stay low continuously from the first FETCH to the last bit of the frame, with no mid-frame glitches.
REQ-028 A pixel's oled_data SHALL be sampled only at the end of its FETCH; input changes during SHIFT SHALL NOT affect bits already latched.

Reset
REQ-029 reset=1 at any clk edge, including mid-SHIFT, SHALL force IDLE and set every output to its reset value on the next clk.
REQ-030 Output reset values: pixel_index=0, sclk=0, mosi=0, cs_n=1, dc=1, busy=0, frame_done=0.
REQ-031 reset SHALL take priority over enable.
REQ-032 After reset is released, the next frame SHALL start at pixel 0.

Verification
REQ-033 Reset then enable=1 with oled_data held at 16'hA5C3: cs_n falls 1 clk later; the first 16 sclk rising edges capture 1010_0101_1100_0011; pixel_index goes to 1 at clk 67.
REQ-034 Pixel model (oled_data = pixel_index registered, CLK_DIV=1, NUM_PIXELS=8): decoded words are 0..7 in order; frame_done pulses once; cs_n is high for exactly 16 clks; the next frame restarts at 0.
REQ-035 Drop enable at pixel 3 of 8: all 8 pixels are sent, then GAP, then IDLE with busy=0; no further sclk edges.
REQ-036 Assert reset for 1 clk in the middle of bit 7 of a pixel: next clk cs_n=1, sclk=0, pixel_index=0; after release with enable=1 the frame restarts at pixel 0.
REQ-037 Toggle oled_data randomly every clk during SHIFT: the shifted word equals the value present at the end of FETCH; mosi never changes while sclk=1.
REQ-038 Check with CLK_DIV=3: each sclk high and low phase is exactly 3 clks; per-pixel time is 98 clks.
